// File: rtl/checkout.sv
// Parking exit controller: computes elapsed time since check-in, bills it in
// rounded-up units by iterative subtraction, and pulses a one-hot slot release.
module checkout #(
    parameter int UNIT      = 60,
    parameter int RATE      = 10,
    parameter int FREE_TIME = 15,
    parameter int FEE_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       selector,
    input  logic [10:0]      timer,
    input  logic [10:0]      p1,
    input  logic [10:0]      p2,
    input  logic [10:0]      p3,
    input  logic [10:0]      p4,
    input  logic [10:0]      p5,
    input  logic [10:0]      p6,
    input  logic [5:0]       occupied,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [10:0]      duration,
    output logic [FEE_W-1:0] fee,
    // "release" is a reserved word in the language, hence the prefix
    output logic [5:0]       slot_release
);

    typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, FINISH} state_t;

    localparam logic [31:0] UNIT_U    = 32'(UNIT);
    localparam logic [10:0] UNIT_W    = 11'(UNIT);
    localparam logic [31:0] FREE_U    = 32'(FREE_TIME);
    localparam logic [43:0] FEE_MAX   = (44'd1 << FEE_W) - 44'd1;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [3:0]        req_sel_q, req_sel_d;
    logic [10:0]       req_time_q, req_time_d;
    logic [2:0]        slot_q, slot_d;
    logic [10:0]       t_q, t_d;
    logic [10:0]       p_q, p_d;
    logic [10:0]       dur_r_q, dur_r_d;
    logic [10:0]       rem_q, rem_d;
    logic [11:0]       units_q, units_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [10:0]       dur_q, dur_d;
    logic [FEE_W-1:0]  fee_q, fee_d;
    logic [5:0]        rel_q, rel_d;

    logic [10:0]       p_sel;
    logic              occ_sel;
    logic [10:0]       diff;
    logic [43:0]       fee_prod;

    always_comb begin
        p_sel   = '0;
        occ_sel = 1'b0;
        case (req_sel_q)
            4'd1: begin p_sel = p1; occ_sel = occupied[0]; end
            4'd2: begin p_sel = p2; occ_sel = occupied[1]; end
            4'd3: begin p_sel = p3; occ_sel = occupied[2]; end
            4'd4: begin p_sel = p4; occ_sel = occupied[3]; end
            4'd5: begin p_sel = p5; occ_sel = occupied[4]; end
            4'd6: begin p_sel = p6; occ_sel = occupied[5]; end
            default: begin p_sel = '0; occ_sel = 1'b0; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = 1'b0;
        req_sel_d  = req_sel_q;
        req_time_d = req_time_q;
        slot_d     = slot_q;
        t_d        = t_q;
        p_d        = p_q;
        dur_r_d    = dur_r_q;
        rem_d      = rem_q;
        units_d    = units_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        dur_d      = dur_q;
        fee_d      = fee_q;
        rel_d      = '0;
        diff       = t_q - p_q;
        fee_prod   = 44'(units_q) * 44'(RATE);

        case (state_q)
            IDLE: begin
                // Request is captured first, then validated on the following edge.
                if (req_q) begin
                    if (occ_sel) begin
                        slot_d  = req_sel_q[2:0];
                        p_d     = p_sel;
                        t_d     = req_time_q;
                        busy_d  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end else begin
                    req_d      = start;
                    req_sel_d  = selector;
                    req_time_d = timer;
                end
            end
            LOAD: begin
                dur_r_d = diff;
                rem_d   = diff;
                units_d = '0;
                state_d = DIVIDE;
            end
            DIVIDE: begin
                if (32'(rem_q) > UNIT_U) begin
                    rem_d   = rem_q - UNIT_W;
                    units_d = units_q + 12'd1;
                end else if (rem_q != '0) begin
                    rem_d   = '0;
                    units_d = units_q + 12'd1;
                    state_d = FINISH;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                dur_d = dur_r_q;
                if (32'(dur_r_q) <= FREE_U)
                    fee_d = '0;
                else if (fee_prod > FEE_MAX)
                    fee_d = '1;
                else
                    fee_d = fee_prod[FEE_W-1:0];
                done_d  = 1'b1;
                rel_d   = 6'd1 << (slot_q - 3'd1);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            req_sel_q  <= '0;
            req_time_q <= '0;
            slot_q     <= '0;
            t_q        <= '0;
            p_q        <= '0;
            dur_r_q    <= '0;
            rem_q      <= '0;
            units_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            dur_q      <= '0;
            fee_q      <= '0;
            rel_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            req_sel_q  <= req_sel_d;
            req_time_q <= req_time_d;
            slot_q     <= slot_d;
            t_q        <= t_d;
            p_q        <= p_d;
            dur_r_q    <= dur_r_d;
            rem_q      <= rem_d;
            units_q    <= units_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            dur_q      <= dur_d;
            fee_q      <= fee_d;
            rel_q      <= rel_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign duration     = dur_q;
    assign fee          = fee_q;
    assign slot_release = rel_q;

endmodule

// File: tb/tb_checkout.sv
// Scoreboard bench for checkout: a default-parameter instance and a saturating
// instance (RATE=1000, FEE_W=8) share stimulus; a monitor checks every done.
module tb_checkout;

    localparam int UNIT   = 60;
    localparam int RATE   = 10;
    localparam int FREE   = 15;
    localparam int FEE_W  = 16;
    localparam int RATE_S = 1000;
    localparam int FEE_WS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  selector;
    logic [10:0] timer;
    logic [10:0] pv [6];
    logic [5:0]  occupied;

    logic              busy, done, error;
    logic [10:0]       duration;
    logic [FEE_W-1:0]  fee;
    logic [5:0]        slot_release;
    logic              busy_s, done_s, error_s;
    logic [10:0]       duration_s;
    logic [FEE_WS-1:0] fee_s;
    logic [5:0]        slot_release_s;

    checkout #(.UNIT(UNIT), .RATE(RATE), .FREE_TIME(FREE), .FEE_W(FEE_W)) dut (
        .clk(clk), .reset(reset), .start(start), .selector(selector), .timer(timer),
        .p1(pv[0]), .p2(pv[1]), .p3(pv[2]), .p4(pv[3]), .p5(pv[4]), .p6(pv[5]),
        .occupied(occupied), .busy(busy), .done(done), .error(error),
        .duration(duration), .fee(fee), .slot_release(slot_release));

    checkout #(.UNIT(UNIT), .RATE(RATE_S), .FREE_TIME(FREE), .FEE_W(FEE_WS)) dut_s (
        .clk(clk), .reset(reset), .start(start), .selector(selector), .timer(timer),
        .p1(pv[0]), .p2(pv[1]), .p3(pv[2]), .p4(pv[3]), .p5(pv[4]), .p6(pv[5]),
        .occupied(occupied), .busy(busy_s), .done(done_s), .error(error_s),
        .duration(duration_s), .fee(fee_s), .slot_release(slot_release_s));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        longint dur;
        longint fee;
        longint fee_s;
        longint rel;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint last_dur = 0;
    longint last_fee = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic longint units_of(input longint dur);
        return (dur + UNIT - 1) / UNIT;
    endfunction

    function automatic longint fee_of(input longint dur, input longint rate, input int fw);
        longint cap, raw;
        cap = (longint'(1) << fw) - 1;
        raw = units_of(dur) * rate;
        if (dur <= FREE) return 0;
        return (raw > cap) ? cap : raw;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", longint'(done), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("duration", duration, e.dur);
                chk("fee", fee, e.fee);
                chk("fee_sat", fee_s, e.fee_s);
                chk("release", slot_release, e.rel);
                chk("done_cycle", cyc, e.cyc);
                chk("done_sat_inst", longint'(done_s), 1);
                last_dur = e.dur;
                last_fee = e.fee;
            end
        end
    end

    // mode: 0 normal, 1 poke start mid-divide, 2 reset mid-divide
    task automatic do_checkout(input int sel, input int p, input int t, input int mode);
        int     edge0, m;
        longint dur;
        exp_t   e;
        @(negedge clk);
        for (int i = 0; i < 6; i++) pv[i] = 11'($urandom_range(0, 2047));
        pv[sel-1] = 11'(p);
        timer     = 11'(t);
        occupied  = 6'($urandom_range(0, 63)) | (6'd1 << (sel - 1));
        selector  = 4'(sel);
        start     = 1'b1;
        edge0     = cyc + 1;
        dur       = longint'((t - p) & 2047);
        m         = (units_of(dur) > 0) ? int'(units_of(dur)) : 1;
        e.dur     = dur;
        e.fee     = fee_of(dur, RATE, FEE_W);
        e.fee_s   = fee_of(dur, RATE_S, FEE_WS);
        e.rel     = longint'(1) << (sel - 1);
        e.cyc     = edge0 + 3 + m;
        if (mode != 2) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            chk("busy", busy, (cyc >= edge0 + 1) ? 1 : 0);
            if (cyc >= edge0 + 1) begin
                timer = 11'($urandom_range(0, 2047));
                for (int k = 0; k < 6; k++) pv[k] = 11'($urandom_range(0, 2047));
            end
            if (mode == 1 && cyc == edge0 + 4) begin
                start    = 1'b1;
                selector = 4'(((sel % 6) + 1));
                occupied = 6'h3f;
            end else begin
                start = 1'b0;
            end
            if (mode == 2 && cyc == edge0 + 4) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_error", error, 0);
                chk("rst_release", slot_release, 0);
                chk("rst_duration", duration, 0);
                chk("rst_fee", fee, 0);
                last_dur = 0;
                last_fee = 0;
                @(negedge clk);
                reset = 1'b0;
                repeat (45) begin
                    @(negedge clk);
                    chk("abort_no_release", slot_release, 0);
                end
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", longint'(done), 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("release_pulse", slot_release, 0);
        chk("busy_after", busy, 0);
    endtask

    task automatic do_reject(input int sel, input logic [5:0] occ);
        @(negedge clk);
        selector = 4'(sel);
        occupied = occ;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej_error_early", error, 0);
        @(negedge clk);
        chk("rej_error", error, 1);
        chk("rej_busy", busy, 0);
        chk("rej_done", done, 0);
        chk("rej_release", slot_release, 0);
        chk("rej_duration", duration, last_dur);
        chk("rej_fee", fee, last_fee);
        @(negedge clk);
        chk("rej_error_pulse", error, 0);
        chk("rej_busy2", busy, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        selector = '0;
        timer    = '0;
        occupied = '0;
        for (int i = 0; i < 6; i++) pv[i] = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_duration", duration, 0);
        chk("reset_fee", fee, 0);
        chk("reset_release", slot_release, 0);
        reset = 1'b0;

        do_checkout(3, 100, 250, 0);     // 150 ticks, 3 units
        do_checkout(1, 2000, 50, 0);     // wrap-around, 98 ticks
        do_checkout(2, 500, 510, 0);     // inside free period
        do_checkout(2, 700, 700, 0);     // zero duration
        do_reject(7, 6'h3f);
        do_reject(4, 6'b110111);
        do_reject(0, 6'h3f);
        do_checkout(3, 100, 250, 1);     // start while busy ignored
        do_checkout(3, 100, 250, 2);     // reset mid-divide
        do_checkout(5, 1000, 1016, 0);   // just above free period
        do_checkout(6, 0, 2047, 0);      // longest duration

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    do_reject(7 + $urandom_range(0, 8), 6'h3f);
                else begin
                    int s;
                    s = $urandom_range(1, 6);
                    do_reject(s, 6'h3f & ~(6'd1 << (s - 1)));
                end
            end else begin
                do_checkout($urandom_range(1, 6), $urandom_range(0, 2047),
                            $urandom_range(0, 2047), 0);
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/checkout.md
Name: checkout

Overview:
- Exit-side counterpart to the parking check-in recorder.
- On a checkout request for slot 1..6, reads that slot's stored 11-bit check-in time and computes the elapsed parking duration against the free-running 11-bit timer, with wrap-around.
- Computes the fee by iterative unit counting, presents duration and fee to the display/payment logic, and pulses a one-hot release to free the slot.

Parameters:
- UNIT, 60, timer ticks per billable unit (partial units round up); must be ≥1.
- RATE, 10, fee charged per billable unit.
- FREE_TIME, 15, duration ≤ FREE_TIME is charged 0.
- FEE_W, 16, fee output width; result saturates at all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  checkout request; sampled only in IDLE.
- selector  input  4  slot number; valid values 1..6.
- timer  input  11  current time, free-running, wraps 2047→0.
- p1..p6  input  11 each  stored check-in times.
- occupied  input  6  bit k-1 set = slot k occupied.
- busy  output  1  high from the edge after start is accepted until done.
- done  output  1  one-cycle pulse; duration/fee valid.
- error  output  1  one-cycle pulse; request rejected.
- duration  output  11  elapsed ticks of the last checkout.
- fee  output  FEE_W  fee of the last checkout.
- release  output  6  one-hot pulse, coincident with done; clears the slot's occupied bit.

Behaviour:
- Reset: state IDLE; busy, done, error, release, duration, fee all 0; internal registers 0.
  - Reset asserted mid-operation aborts immediately.
  - No done or release for the aborted request.
- FSM states: IDLE, LOAD, DIVIDE, FINISH.
- IDLE, start=1:
  - Valid request (selector in 1..6 and the matching occupied bit = 1): latch slot index, the selected pX and timer; go to LOAD; busy=1.
  - Invalid request: error=1 for one cycle; stay IDLE; other outputs unchanged.
- LOAD (1 cycle):
  - duration_r = (timer_latched − pX_latched) mod 2048, using 11-bit wrapping subtraction.
  - rem = duration_r; units = 0; go to DIVIDE.
- DIVIDE, one edge per iteration:
  - If rem > UNIT: rem −= UNIT, units += 1.
  - Else if rem > 0: rem = 0, units += 1, go to FINISH.
  - Else (rem = 0 on entry): go to FINISH, units stays 0.
  - Occupies M = max(N,1) cycles, where N = ceil(duration/UNIT).
- FINISH (1 cycle, registered outputs at its exit edge):
  - duration ← duration_r.
  - fee ← 0 if duration_r ≤ FREE_TIME, else min(units × RATE, 2^FEE_W − 1).
  - done=1, release one-hot = slot, busy=0; go to IDLE.
- Latency: done is visible in the cycle after edge 3+M, counting edge 0 as the edge that samples start.
  - Example: N=3 → done after edge 6.
- done, error and release are single-cycle pulses; deasserted the following edge.
- duration/fee hold until the next successful checkout or reset.
- start while busy is ignored: no error, no effect on the running calculation.
- Inputs other than those latched at acceptance may change freely while busy.
- A new start is accepted on the edge after done (back-to-back).

Test Plan:
- Normal: occupied=6'b000100, p3=100, timer=250, selector=3, start pulse → duration=150, fee=30, release=6'b000100, done 1 cycle after edge 6, busy high for edges 1..5.
- Wrap-around: p1=2000, timer=50, selector=1, occupied[0]=1 → duration=98, fee=20 (2 units), done after edge 5.
- Free period and zero: p2=500, timer=510 → duration=10, fee=0. Then p2=timer → duration=0, fee=0, done after edge 4; release pulses in both cases.
- Rejects: selector=7, or selector=4 with occupied[3]=0 → error pulse 1 cycle, busy/done/release stay 0, duration/fee unchanged.
- Busy/reset: during DIVIDE of a 150-tick checkout, a second start is ignored. In a separate run, assert reset mid-DIVIDE → all outputs 0 immediately, no done/release; a subsequent valid start completes normally.
- Saturation: RATE=1000, FEE_W=8, duration=150 → fee=255.
